// File: rtl/fb_write_arbiter.sv
// Round-robin sharing of the frame-buffer write port among NREQ drawing
// requesters, plus a full-screen clear sequencer that fills every pixel.
module fb_write_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 19,
   parameter int unsigned DW   = 3,
   parameter int unsigned NPIX = 307200
) (
   input  logic                 clk_100mhz_buf,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      ack,
   input  logic                 clear_start,
   input  logic [DW-1:0]        clear_color,
   output logic                 clear_busy,
   output logic                 clear_done,
   input  logic                 wr_ready,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [DW-1:0]        wr_data
);

   localparam int unsigned   PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] color_q, color_d;
   logic          wr_en_d;
   logic [AW-1:0] wr_addr_d;
   logic [DW-1:0] wr_data_d;
   logic          busy_d, done_d;

   logic [PW-1:0] gnt_idx;
   logic          gnt_any;
   logic [PW:0]   cand;
   logic [PW-1:0] ptr_nxt;

   // First set request at or after the pointer, wrapping modulo NREQ
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(i);
         if (cand >= (PW+1)'(NREQ)) begin
            cand = cand - (PW+1)'(NREQ);
         end
         if (!gnt_any && req[cand[PW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[PW-1:0];
         end
      end
   end

   assign ptr_nxt = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

   // Next-state, acceptance and write-port selection
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      color_d   = color_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      ack       = '0;
      case (state_q)
         S_IDLE: begin
            if (clear_start) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
               color_d = clear_color;
            end else if (wr_ready && gnt_any) begin
               ack[gnt_idx] = 1'b1;
               wr_en_d      = 1'b1;
               wr_addr_d    = req_addr[gnt_idx*AW +: AW];
               wr_data_d    = req_data[gnt_idx*DW +: DW];
               ptr_d        = ptr_nxt;
            end
         end
         S_CLEAR: begin
            if (wr_ready) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               wr_data_d = color_q;
               // Stop on the last pixel so the counter never wraps
               if (cnt_q == LAST_PIX) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (!rst_n) begin
         ack = '0;
      end
   end

   assign busy_d = (state_d == S_CLEAR);
   assign done_d = (state_d == S_DONE);

   // State and registered outputs
   always_ff @(posedge clk_100mhz_buf or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         color_q    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         color_q    <= color_d;
         wr_en      <= wr_en_d;
         wr_addr    <= wr_addr_d;
         wr_data    <= wr_data_d;
         clear_busy <= busy_d;
         clear_done <= done_d;
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed vectors, a behavioural model checked on
// every falling edge, and literal expectations for the key scenarios.
module tb_fb_write_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 19;
   localparam int DW   = 3;
   localparam int NPIX = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     ack;
   logic                clear_start;
   logic [DW-1:0]       clear_color;
   logic                clear_busy;
   logic                clear_done;
   logic                wr_ready;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [DW-1:0]       wr_data;

   int checks   = 0;
   int failures = 0;

   // Model state: mode 0 = arbitrating, 1 = clearing, 2 = clear finished
   int            m_mode, m_ptr, m_cnt;
   logic [DW-1:0] m_color;
   logic          m_wr_en, m_busy, m_done;
   logic [AW-1:0] m_wr_addr;
   logic [DW-1:0] m_wr_data;

   // Observed traffic
   logic [AW-1:0] waddr_log[$];
   logic [DW-1:0] wdata_log[$];
   int            glog[$];
   int            done_cnt = 0;
   int            busy_cnt = 0;

   fb_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NPIX(NPIX)) dut (
      .clk_100mhz_buf (clk),
      .rst_n          (rst_n),
      .req            (req),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .ack            (ack),
      .clear_start    (clear_start),
      .clear_color    (clear_color),
      .clear_busy     (clear_busy),
      .clear_done     (clear_done),
      .wr_ready       (wr_ready),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_req(input int ptr, input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ack();
      logic [NREQ-1:0] a;
      int g;
      a = '0;
      if (rst_n !== 1'b1 || m_mode != 0 || !wr_ready || clear_start) return a;
      g = first_req(m_ptr, req);
      if (g >= 0) a[g] = 1'b1;
      return a;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_ptr = 0; m_cnt = 0; m_color = '0;
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
      m_busy = 1'b0; m_done = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic model_step();
      int g;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_wr_en = 1'b0;
      if (m_mode == 0) begin
         if (clear_start) begin
            m_mode = 1; m_cnt = 0; m_color = clear_color;
         end else if (wr_ready) begin
            g = first_req(m_ptr, req);
            if (g >= 0) begin
               m_wr_en   = 1'b1;
               m_wr_addr = req_addr[g*AW +: AW];
               m_wr_data = req_data[g*DW +: DW];
               m_ptr     = (g + 1) % NREQ;
            end
         end
      end else if (m_mode == 1) begin
         if (wr_ready) begin
            m_wr_en   = 1'b1;
            m_wr_addr = AW'(m_cnt);
            m_wr_data = m_color;
            if (m_cnt == NPIX - 1) m_mode = 2;
            else m_cnt++;
         end
      end else begin
         m_mode = 0;
      end
      m_busy = (m_mode == 1);
      m_done = (m_mode == 2);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_rq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // Compare process: DUT against model every falling edge, and traffic logging
   initial begin
      logic [NREQ-1:0] ea;
      forever begin
         @(negedge clk);
         ea = exp_ack();
         chk("ack", 32'(ack), 32'(ea));
         chk("wr_en", 32'(wr_en), 32'(m_wr_en));
         chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
         chk("wr_data", 32'(wr_data), 32'(m_wr_data));
         chk("clear_busy", 32'(clear_busy), 32'(m_busy));
         chk("clear_done", 32'(clear_done), 32'(m_done));
         if (wr_en) begin
            waddr_log.push_back(wr_addr);
            wdata_log.push_back(wr_data);
         end
         for (int k = 0; k < NREQ; k++) begin
            if (ack[k]) glog.push_back(k);
         end
         if (clear_done) done_cnt++;
         if (clear_busy) busy_cnt++;
      end
   end

   initial begin
      int wb, gb, d0, b0;
      rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0;
      clear_start = 1'b0; clear_color = '0; wr_ready = 1'b0;
      model_reset();
      repeat (2) tick();
      chk("reset_wr_en", 32'(wr_en), 0);
      chk("reset_wr_addr", 32'(wr_addr), 0);
      chk("reset_busy", 32'(clear_busy), 0);
      rst_n = 1'b1;
      tick();

      // Single requester, then pointer follow-up
      wr_ready = 1'b1;
      set_rq(2, 19'h00123, 3'd3);
      req = 4'b0100;
      #1 chk("t1_ack", 32'(ack), 32'h4);
      tick();
      req = '0;
      chk("t1_wr_en", 32'(wr_en), 1);
      chk("t1_wr_addr", 32'(wr_addr), 32'h123);
      chk("t1_wr_data", 32'(wr_data), 3);
      set_rq(0, 19'h00200, 3'd1);
      req = 4'b0101;
      #1 chk("t1_ptr3_ack", 32'(ack), 32'h1);
      tick();
      #1 chk("t1_ptr1_ack", 32'(ack), 32'h4);
      tick();
      req = 4'b1000;
      set_rq(3, 19'h00300, 3'd2);
      #1 chk("t1_ptr3b_ack", 32'(ack), 32'h8);
      tick();
      req = '0;
      tick();

      // All four requesters held: fair rotation from pointer 0
      for (int i = 0; i < NREQ; i++) set_rq(i, AW'(32'h1000 + i), DW'(i));
      gb = glog.size(); wb = waddr_log.size();
      req = 4'b1111;
      repeat (8) tick();
      req = '0;
      repeat (2) tick();
      chk("t2_grants", 32'(glog.size() - gb), 8);
      chk("t2_writes", 32'(waddr_log.size() - wb), 8);
      if (glog.size() - gb == 8 && waddr_log.size() - wb == 8) begin
         for (int k = 0; k < 8; k++) begin
            chk("t2_order", 32'(glog[gb+k]), 32'(k % 4));
            chk("t2_addr", 32'(waddr_log[wb+k]), 32'h1000 + 32'(k % 4));
         end
      end

      // Backpressure: only ready cycles ack and write
      wb = waddr_log.size();
      set_rq(1, 19'h00010, 3'd1);
      req = 4'b0010; wr_ready = 1'b1;
      tick();
      set_rq(1, 19'h00011, 3'd2); wr_ready = 1'b0;
      #1 chk("t3_noack", 32'(ack), 0);
      tick();
      wr_ready = 1'b1;
      tick();
      set_rq(1, 19'h00012, 3'd3); wr_ready = 1'b0;
      tick();
      req = '0; wr_ready = 1'b1;
      repeat (2) tick();
      chk("t3_writes", 32'(waddr_log.size() - wb), 2);
      if (waddr_log.size() - wb == 2) begin
         chk("t3_addr0", 32'(waddr_log[wb]), 32'h10);
         chk("t3_addr1", 32'(waddr_log[wb+1]), 32'h11);
      end

      // Clear with a concurrent requester held off until IDLE
      wb = waddr_log.size(); d0 = done_cnt; b0 = busy_cnt;
      set_rq(3, 19'h00777, 3'd6);
      req = 4'b1000; clear_color = 3'd5; clear_start = 1'b1; wr_ready = 1'b1;
      #1 chk("t4_ack_at_start", 32'(ack), 0);
      tick();
      clear_start = 1'b0;
      chk("t4_busy", 32'(clear_busy), 1);
      chk("t4_ack_in_clear", 32'(ack), 0);
      repeat (16) tick();
      chk("t4_done", 32'(clear_done), 1);
      chk("t4_busy_off", 32'(clear_busy), 0);
      tick();
      #1 chk("t4_ack_after", 32'(ack), 32'h8);
      tick();
      req = '0;
      repeat (2) tick();
      chk("t4_writes", 32'(waddr_log.size() - wb), 17);
      chk("t4_done_cnt", 32'(done_cnt - d0), 1);
      chk("t4_busy_cnt", 32'(busy_cnt - b0), 16);
      if (waddr_log.size() - wb == 17) begin
         for (int k = 0; k < 16; k++) begin
            chk("t4_clr_addr", 32'(waddr_log[wb+k]), 32'(k));
            chk("t4_clr_data", 32'(wdata_log[wb+k]), 5);
         end
         chk("t4_req_addr", 32'(waddr_log[wb+16]), 32'h777);
         chk("t4_req_data", 32'(wdata_log[wb+16]), 6);
      end

      // Clear under random backpressure; second start mid-run is ignored
      wb = waddr_log.size(); d0 = done_cnt;
      clear_color = 3'd2; clear_start = 1'b1; wr_ready = 1'b1;
      tick();
      for (int i = 0; i < 80; i++) begin
         wr_ready = (i >= 50) ? 1'b1 : 1'($urandom_range(0, 1));
         if (i == 8) begin
            clear_start = 1'b1; clear_color = 3'd7;
         end else begin
            clear_start = 1'b0;
         end
         tick();
      end
      chk("t5_writes", 32'(waddr_log.size() - wb), 16);
      chk("t5_done_cnt", 32'(done_cnt - d0), 1);
      if (waddr_log.size() - wb == 16) begin
         for (int k = 0; k < 16; k++) begin
            chk("t5_addr", 32'(waddr_log[wb+k]), 32'(k));
            chk("t5_data", 32'(wdata_log[wb+k]), 2);
         end
      end

      // Reset mid-clear at counter 7
      d0 = done_cnt;
      clear_color = 3'd4; clear_start = 1'b1; wr_ready = 1'b1;
      tick();
      clear_start = 1'b0;
      repeat (7) tick();
      chk("t6_busy_before", 32'(clear_busy), 1);
      rst_n = 1'b0;
      model_reset();
      req = 4'b1111;
      #1;
      chk("t6_wr_en", 32'(wr_en), 0);
      chk("t6_wr_addr", 32'(wr_addr), 0);
      chk("t6_wr_data", 32'(wr_data), 0);
      chk("t6_busy", 32'(clear_busy), 0);
      chk("t6_ack", 32'(ack), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      #1 chk("t6_restart_ack", 32'(ack), 32'h1);
      tick();
      req = '0;
      repeat (20) tick();
      chk("t6_no_done", 32'(done_cnt - d0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
